mcu_spi_phy: RTL and testbench



---
 rtl/mcu_spi_phy_pkg.sv | 21 ++
 rtl/mcu_spi_phy_if.sv | 24 ++
 rtl/mcu_ready_filter.sv | 51 +++++
 rtl/mcu_spi_phy.sv | 128 ++++++++++++
 tb/tb_mcu_spi_phy.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/mcu_spi_phy_pkg.sv
// Shared types and defaults for the MCU SPI physical-side companion block.
// Latency: n/a (declarations only). Backpressure: n/a.
// Holds the FSM state encoding and parameter defaults used by mcu_spi_phy and its filter.
package mcu_spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_HIGH = 2'd1,
        S_WAIT_LOW  = 2'd2
    } phy_state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_FILTER_LEN     = 3;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Counter width that stays legal for a modulus of 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mcu_spi_phy_if.sv
// Sequencer/MCU-side signal bundle for mcu_spi_phy.
// Latency: n/a (wires only). Backpressure: none; READY is the only flow control.
// master = sequencer/board side, slave = the phy.
interface mcu_spi_phy_if;
    logic MCUReadyPin;
    logic nMCUSel;
    logic SPIClkRunning;
    logic SPIClkStretch;
    logic ClearTimeout;
    logic MCUReadyFallingEdge;
    logic MCUReadySync;
    logic SPIClkEn;
    logic TimeoutFlag;

    modport master (
        output MCUReadyPin, nMCUSel, SPIClkRunning, SPIClkStretch, ClearTimeout,
        input  MCUReadyFallingEdge, MCUReadySync, SPIClkEn, TimeoutFlag
    );

    modport slave (
        input  MCUReadyPin, nMCUSel, SPIClkRunning, SPIClkStretch, ClearTimeout,
        output MCUReadyFallingEdge, MCUReadySync, SPIClkEn, TimeoutFlag
    );
endinterface

// File: rtl/mcu_ready_filter.sv
// Synchronizes the async READY pin and glitch-filters it into a stable level plus change/fall pulses.
// Latency: SYNC_STAGES+FILTER_LEN SClk edges from first sampling edge to level change.
// Backpressure: none; pulses are one cycle and must be consumed when seen.
module mcu_ready_filter
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FILTER_LEN  = DEF_FILTER_LEN
) (
    input  logic SClk,
    input  logic nReset,
    input  logic ready_pin,
    output logic ready_level,
    output logic ready_chg,
    output logic ready_fall
);
    localparam int CW = cnt_width(FILTER_LEN);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            sync_q      <= '0;
            cnt_q       <= '0;
            ready_level <= 1'b0;
            ready_chg   <= 1'b0;
            ready_fall  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], ready_pin};
            ready_chg  <= 1'b0;
            ready_fall <= 1'b0;
            if (synced != ready_level) begin
                // Only the FILTER_LEN-th consecutive disagreeing sample flips the level.
                if (cnt_q == CW'(FILTER_LEN - 1)) begin
                    ready_level <= synced;
                    cnt_q       <= '0;
                    ready_chg   <= 1'b1;
                    ready_fall  <= ready_level;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end
endmodule

// File: rtl/mcu_spi_phy.sv
// MCU READY conditioning, falling-edge strobe FSM and SPI clock-enable; stall timeout under MCU_READY_TIMEOUT_EN.
// Latency: strobe one SClk after the filtered level falls; SPIClkEn is combinational (zero latency).
// Backpressure: none; without MCU_READY_TIMEOUT_EN the FSM waits on the MCU indefinitely.
module mcu_spi_phy
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic          SClk,
    input logic          nReset,
    mcu_spi_phy_if.slave bus
);
    phy_state_t state_q, state_d;
    logic       strobe_q, strobe_d;
    logic       ready_level, ready_chg, ready_fall;
    logic       genuine_edge;

    mcu_ready_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_filter (
        .SClk        (SClk),
        .nReset      (nReset),
        .ready_pin   (bus.MCUReadyPin),
        .ready_level (ready_level),
        .ready_chg   (ready_chg),
        .ready_fall  (ready_fall)
    );

    assign genuine_edge = (state_q == S_WAIT_LOW) && ready_fall;

`ifdef MCU_READY_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          flag_q, flag_d;
    logic          expire;

    always_comb begin
        tcnt_d = tcnt_q;
        expire = 1'b0;
        if (state_q != S_IDLE) begin
            if ((bus.SPIClkStretch || !bus.SPIClkRunning) && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                expire = 1'b1;
                tcnt_d = '0;
            end else if (ready_chg || (bus.SPIClkRunning && !bus.SPIClkStretch)) begin
                tcnt_d = '0;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
        if (!bus.nMCUSel == 1'b0) begin
            tcnt_d = '0;
            expire = 1'b0;
        end
        // A real edge landing on the expiry cycle is not a stall.
        flag_d = flag_q;
        if (expire && !genuine_edge) begin
            flag_d = 1'b1;
        end else if (bus.ClearTimeout) begin
            flag_d = 1'b0;
        end
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            tcnt_q <= '0;
            flag_q <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            flag_q <= flag_d;
        end
    end

    assign bus.TimeoutFlag = flag_q;
`else
    logic expire;
    logic unused_tmo;

    assign expire          = 1'b0;
    assign unused_tmo      = bus.ClearTimeout ^ ready_chg ^ TIMEOUT_CYCLES[0];
    assign bus.TimeoutFlag = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        strobe_d = 1'b0;
        unique case (state_q)
            S_IDLE:      state_d = S_WAIT_HIGH;
            S_WAIT_HIGH: if (ready_level) state_d = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (ready_fall) begin
                    strobe_d = 1'b1;
                    state_d  = S_WAIT_HIGH;
                end
            end
            default:     state_d = S_IDLE;
        endcase
        if (expire) begin
            strobe_d = 1'b1;
            state_d  = S_WAIT_HIGH;
        end
        // Deselect overrides everything, including an edge on the same cycle.
        if (bus.nMCUSel) begin
            state_d  = S_IDLE;
            strobe_d = 1'b0;
        end
        if (strobe_q) begin
            strobe_d = 1'b0;
        end
    end

    always_ff @(posedge SClk or negedge nReset) begin
        if (!nReset) begin
            state_q  <= S_IDLE;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            strobe_q <= strobe_d;
        end
    end

    assign bus.MCUReadyFallingEdge = strobe_q;
    assign bus.MCUReadySync        = ready_level;
    assign bus.SPIClkEn            = bus.SPIClkRunning & ~bus.SPIClkStretch & ~bus.nMCUSel;
endmodule

// File: tb/tb_mcu_spi_phy.sv
// Directed bench for mcu_spi_phy: clock-enable truth table plus hand-timed READY sequences.
// Timeout expectations apply only when MCU_READY_TIMEOUT_EN is defined.
module tb_mcu_spi_phy;
    import mcu_spi_pkg::*;

    logic SClk = 1'b0;
    logic nReset;
    int   n_cmp = 0;
    int   n_err = 0;
    int   strobe_cnt = 0;
    int   dbl_cnt = 0;
    logic prev_strobe = 1'b0;

    mcu_spi_phy_if bus ();

    mcu_spi_phy #(
        .SYNC_STAGES    (2),
        .FILTER_LEN     (3),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .SClk   (SClk),
        .nReset (nReset),
        .bus    (bus)
    );

    always #5 SClk = ~SClk;

    typedef struct {
        logic nsel;
        logic run;
        logic stretch;
        logic exp_en;
    } en_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one cycle; sample 1ns after the edge and tally strobes.
    task automatic step();
        @(posedge SClk);
        #1;
        if (bus.MCUReadyFallingEdge === 1'b1) begin
            strobe_cnt++;
            if (prev_strobe) dbl_cnt++;
        end
        prev_strobe = bus.MCUReadyFallingEdge;
    endtask

    initial begin
        en_vec_t vecs[8];
        int waited;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0};

        nReset            = 1'b1;
        bus.MCUReadyPin   = 1'b0;
        bus.nMCUSel       = 1'b1;
        bus.SPIClkRunning = 1'b0;
        bus.SPIClkStretch = 1'b0;
        bus.ClearTimeout  = 1'b0;
        #2 nReset = 1'b0;
        #1;
        check("rst_strobe", 32'(bus.MCUReadyFallingEdge), 0);
        check("rst_sync",   32'(bus.MCUReadySync), 0);
        check("rst_flag",   32'(bus.TimeoutFlag), 0);
        check("rst_clken",  32'(bus.SPIClkEn), 0);
        check("rst_state",  32'(dut.state_q), 32'(S_IDLE));
        step();
        step();
        nReset = 1'b1;
        step();

        // SPIClkEn is combinational: compare in the same cycle as the input change.
        for (int i = 0; i < 8; i++) begin
            bus.nMCUSel       = vecs[i].nsel;
            bus.SPIClkRunning = vecs[i].run;
            bus.SPIClkStretch = vecs[i].stretch;
            #1;
            check($sformatf("clken_vec%0d", i), 32'(bus.SPIClkEn), 32'(vecs[i].exp_en));
        end

        // Clean rise then fall: level after 5 edges, strobe 6 edges after the fall.
        bus.nMCUSel = 1'b0; bus.SPIClkRunning = 1'b1; bus.SPIClkStretch = 1'b0;
        repeat (3) step();
        bus.MCUReadyPin = 1'b1;
        repeat (4) step();
        check("rise_not_yet", 32'(bus.MCUReadySync), 0);
        step();
        check("rise_at_5", 32'(bus.MCUReadySync), 1);
        repeat (20) step();
        strobe_cnt = 0;
        bus.MCUReadyPin = 1'b0;
        repeat (5) step();
        check("fall_sync_at_5", 32'(bus.MCUReadySync), 0);
        check("strobe_not_yet", 32'(bus.MCUReadyFallingEdge), 0);
        step();
        check("strobe_at_6", 32'(bus.MCUReadyFallingEdge), 1);
        step();
        check("strobe_one_cycle", 32'(bus.MCUReadyFallingEdge), 0);
        repeat (5) step();
        check("strobe_count_clean", 32'(strobe_cnt), 1);

        // Two-cycle low glitch while READY is high must be absorbed.
        bus.MCUReadyPin = 1'b1;
        repeat (8) step();
        strobe_cnt = 0;
        bus.MCUReadyPin = 1'b0;
        step();
        step();
        bus.MCUReadyPin = 1'b1;
        repeat (10) step();
        check("glitch_sync", 32'(bus.MCUReadySync), 1);
        check("glitch_strobes", 32'(strobe_cnt), 0);

        // Filtered fall coincides with deselect: no strobe, back to idle.
        strobe_cnt = 0;
        bus.MCUReadyPin = 1'b0;
        repeat (5) step();
        check("desel_sync_fell", 32'(bus.MCUReadySync), 0);
        bus.nMCUSel = 1'b1;
        step();
        check("desel_no_strobe", 32'(bus.MCUReadyFallingEdge), 0);
        check("desel_state", 32'(dut.state_q), 32'(S_IDLE));
        repeat (3) step();
        check("desel_strobes", 32'(strobe_cnt), 0);

        // Reset in S_WAIT_LOW with the filter part-way through counting a fall.
        bus.nMCUSel = 1'b0;
        bus.MCUReadyPin = 1'b1;
        repeat (8) step();
        check("pre_rst_state", 32'(dut.state_q), 32'(S_WAIT_LOW));
        bus.MCUReadyPin = 1'b0;
        repeat (3) step();
        bus.SPIClkRunning = 1'b0;
        nReset = 1'b0;
        #1;
        check("midrst_strobe", 32'(bus.MCUReadyFallingEdge), 0);
        check("midrst_sync",   32'(bus.MCUReadySync), 0);
        check("midrst_flag",   32'(bus.TimeoutFlag), 0);
        check("midrst_clken",  32'(bus.SPIClkEn), 0);
        check("midrst_state",  32'(dut.state_q), 32'(S_IDLE));
        step();
        nReset = 1'b1;
        bus.SPIClkRunning = 1'b1;
        strobe_cnt = 0;
        repeat (15) step();
        check("postrst_no_strobe", 32'(strobe_cnt), 0);
        bus.MCUReadyPin = 1'b1;
        repeat (8) step();
        bus.MCUReadyPin = 1'b0;
        repeat (8) step();
        check("postrst_fresh_strobe", 32'(strobe_cnt), 1);

        // Stall with READY held low.
        bus.nMCUSel = 1'b1;
        step();
        bus.nMCUSel = 1'b0;
        bus.SPIClkRunning = 1'b0;
        bus.SPIClkStretch = 1'b1;
        strobe_cnt = 0;
`ifdef MCU_READY_TIMEOUT_EN
        // Edge 1 enters S_WAIT_HIGH, edges 2..16 count to 15, edge 17 expires.
        waited = 0;
        while (strobe_cnt == 0 && waited < 100) begin
            step();
            waited++;
        end
        check("tmo_latency", 32'(waited), 17);
        check("tmo_flag_set", 32'(bus.TimeoutFlag), 1);
        bus.nMCUSel = 1'b1;
        step();
        check("tmo_flag_sticky", 32'(bus.TimeoutFlag), 1);
        bus.ClearTimeout = 1'b1;
        step();
        bus.ClearTimeout = 1'b0;
        check("tmo_flag_clear", 32'(bus.TimeoutFlag), 0);
`else
        waited = 0;
        repeat (40) begin
            step();
            waited++;
        end
        check("stall_no_strobe", 32'(strobe_cnt), 0);
        check("stall_no_flag", 32'(bus.TimeoutFlag), 0);
`endif
        bus.nMCUSel = 1'b1;
        bus.SPIClkStretch = 1'b0;
        step();

        check("no_back_to_back", 32'(dbl_cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
